// File: rtl/mii_rx_framer.sv
// MII/GMII receive framer: preamble/SFD hunt, lane-to-byte assembly, sof/eof/err tagging into a FWFT FIFO.
// Latency: last lane to eof on m_* is 2 cycles; no input backpressure, FIFO pressure truncates the frame (err on eof).
module mii_rx_framer #(
  parameter int DATA_W     = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_LEN    = 1522
) (
  input  logic              mii_clk,
  input  logic              reset,
  input  logic              mii_dv,
  input  logic              mii_er,
  input  logic [DATA_W-1:0] mii_d,
  output logic [7:0]        m_data,
  output logic              m_sof,
  output logic              m_eof,
  output logic              m_err,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [15:0]       good_cnt,
  output logic [15:0]       bad_cnt,
  output logic              busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [7:0] PRE8 = 8'h55;
  localparam logic [7:0] SFD8 = (DATA_W == 8) ? 8'hD5 : 8'h0D;
  localparam logic [DATA_W-1:0] PRE = PRE8[DATA_W-1:0];
  localparam logic [DATA_W-1:0] SFD = SFD8[DATA_W-1:0];

  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DROP} state_t;

  typedef struct packed {
    logic       sof;
    logic       eof;
    logic       err;
    logic [7:0] dat;
  } ent_t;

  state_t        state;
  logic          first_cyc;
  logic          phase;
  logic [3:0]    lo_nib;
  logic          hold_vld;
  logic [7:0]    hold_dat;
  logic          sof_pend;
  logic          err_acc;
  logic          trunc;
  logic [LW-1:0] byte_cnt;

  ent_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fifo_cnt;
  ent_t          head;
  ent_t          push_ent;

  logic       push;
  logic       pop;
  logic       room1;
  logic       room2;
  logic       byte_done;
  logic       accept;
  logic       end_err;
  logic [7:0] new_byte;

  // A non-eof write needs two free slots so the eof entry of a started frame always fits.
  always_comb begin
    pop       = m_valid & m_ready;
    room1     = (fifo_cnt != CW'(FIFO_DEPTH)) | pop;
    room2     = fifo_cnt <= CW'(FIFO_DEPTH - 2);
    new_byte  = (DATA_W == 8) ? 8'(mii_d) : 8'({mii_d, lo_nib});
    byte_done = mii_dv & ((DATA_W == 8) | phase);
    accept    = byte_done & ~trunc & (byte_cnt < LW'(MAX_LEN)) & (~hold_vld | room2);
    end_err   = err_acc | trunc | phase;
    push      = 1'b0;
    push_ent  = '0;
    if (state == PAYLOAD) begin
      if (!mii_dv) begin
        push     = hold_vld & room1;
        push_ent = '{sof: sof_pend, eof: 1'b1, err: end_err, dat: hold_dat};
      end else begin
        push     = accept & hold_vld;
        push_ent = '{sof: sof_pend, eof: 1'b0, err: 1'b0, dat: hold_dat};
      end
    end
  end

  always_ff @(posedge mii_clk) begin
    if (reset) begin
      state     <= IDLE;
      first_cyc <= 1'b1;
      phase     <= 1'b0;
      lo_nib    <= '0;
      hold_vld  <= 1'b0;
      hold_dat  <= '0;
      sof_pend  <= 1'b1;
      err_acc   <= 1'b0;
      trunc     <= 1'b0;
      byte_cnt  <= '0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
    end else begin
      first_cyc <= 1'b0;
      case (state)
        IDLE: begin
          phase    <= 1'b0;
          hold_vld <= 1'b0;
          sof_pend <= 1'b1;
          err_acc  <= 1'b0;
          trunc    <= 1'b0;
          byte_cnt <= '0;
          // dv already high when reset lifts means we joined mid-frame
          if (mii_dv) begin
            if (first_cyc) begin
              state <= DROP;
            end else if (!mii_er && mii_d == PRE) begin
              state <= PREAMBLE;
            end else begin
              state   <= DROP;
              bad_cnt <= bad_cnt + 16'd1;
            end
          end
        end
        PREAMBLE: begin
          if (!mii_dv) begin
            state   <= IDLE;
            bad_cnt <= bad_cnt + 16'd1;
          end else if (mii_er || (mii_d != PRE && mii_d != SFD)) begin
            state   <= DROP;
            bad_cnt <= bad_cnt + 16'd1;
          end else if (mii_d == SFD) begin
            state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (!mii_dv) begin
            state <= IDLE;
            if (push && !end_err) good_cnt <= good_cnt + 16'd1;
            else                  bad_cnt  <= bad_cnt + 16'd1;
          end else begin
            if (mii_er) err_acc <= 1'b1;
            if (DATA_W == 4) phase <= ~phase;
            lo_nib <= mii_d[3:0];
            if (byte_done) begin
              if (accept) begin
                hold_dat <= new_byte;
                hold_vld <= 1'b1;
                byte_cnt <= byte_cnt + 1'b1;
                if (push) sof_pend <= 1'b0;
              end else begin
                trunc <= 1'b1;
              end
            end
          end
        end
        DROP: begin
          if (!mii_dv) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge mii_clk) begin
    if (push) mem[wr_ptr] <= push_ent;
  end

  always_ff @(posedge mii_clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

  assign head    = mem[rd_ptr];
  assign m_valid = (fifo_cnt != '0);
  assign m_data  = m_valid ? head.dat : 8'h00;
  assign m_sof   = m_valid & head.sof;
  assign m_eof   = m_valid & head.eof;
  assign m_err   = m_valid & head.err;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mii_rx_framer.sv
// Directed bench: a 4-bit MII instance (depth 16) and an 8-bit GMII instance (depth 16, MAX_LEN 64).
module tb_mii_rx_framer;

  logic mii_clk = 1'b0;
  always #5 mii_clk = ~mii_clk;

  logic        reset;
  logic        dv4, er4, rdy4;
  logic [3:0]  d4;
  logic [7:0]  dat4;
  logic        sof4, eof4, err4, val4, busy4;
  logic [15:0] good4, bad4;
  logic        dv8, er8, rdy8;
  logic [7:0]  d8;
  logic [7:0]  dat8;
  logic        sof8, eof8, err8, val8, busy8;
  logic [15:0] good8, bad8;

  int checks = 0;
  int failures = 0;
  logic [10:0] cap4 [$];
  logic [10:0] cap8 [$];

  mii_rx_framer #(.DATA_W(4), .FIFO_DEPTH(16), .MAX_LEN(1522)) u4 (
    .mii_clk(mii_clk), .reset(reset), .mii_dv(dv4), .mii_er(er4), .mii_d(d4),
    .m_data(dat4), .m_sof(sof4), .m_eof(eof4), .m_err(err4), .m_valid(val4), .m_ready(rdy4),
    .good_cnt(good4), .bad_cnt(bad4), .busy(busy4));

  mii_rx_framer #(.DATA_W(8), .FIFO_DEPTH(16), .MAX_LEN(64)) u8 (
    .mii_clk(mii_clk), .reset(reset), .mii_dv(dv8), .mii_er(er8), .mii_d(d8),
    .m_data(dat8), .m_sof(sof8), .m_eof(eof8), .m_err(err8), .m_valid(val8), .m_ready(rdy8),
    .good_cnt(good8), .bad_cnt(bad8), .busy(busy8));

  // Entries accepted by the consumer, as {sof, eof, err, data}.
  always @(negedge mii_clk) begin
    if (val4 && rdy4) cap4.push_back({sof4, eof4, err4, dat4});
    if (val8 && rdy8) cap8.push_back({sof8, eof8, err8, dat8});
  end

  task automatic tick4(input logic dv, input logic [3:0] d, input logic er);
    @(posedge mii_clk); #2;
    dv4 = dv; d4 = d; er4 = er;
  endtask

  task automatic tick8(input logic dv, input logic [7:0] d, input logic er);
    @(posedge mii_clk); #2;
    dv8 = dv; d8 = d; er8 = er;
  endtask

  task automatic pay4(input logic [7:0] b, input logic er);
    tick4(1'b1, b[3:0], er);
    tick4(1'b1, b[7:4], 1'b0);
  endtask

  task automatic pre4(input int n);
    repeat (n) tick4(1'b1, 4'h5, 1'b0);
    tick4(1'b1, 4'hD, 1'b0);
  endtask

  task automatic pre8(input int n);
    repeat (n) tick8(1'b1, 8'h55, 1'b0);
    tick8(1'b1, 8'hD5, 1'b0);
  endtask

  task automatic settle4(input int n, input int budget);
    int t = 0;
    while (cap4.size() < n && t < budget) begin @(negedge mii_clk); t++; end
    repeat (4) @(negedge mii_clk);
  endtask

  task automatic settle8(input int n, input int budget);
    int t = 0;
    while (cap8.size() < n && t < budget) begin @(negedge mii_clk); t++; end
    repeat (4) @(negedge mii_clk);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge mii_clk);
    @(negedge mii_clk);
    checks++; if (val4 !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", val4); end
    checks++; if (dat4 !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", dat4); end
    checks++; if ({sof4, eof4, err4} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {sof4, eof4, err4}); end
    checks++; if (good4 !== 16'd0) begin failures++; $display("FAIL reset_good got=%0d exp=0", good4); end
    checks++; if (bad4 !== 16'd0) begin failures++; $display("FAIL reset_bad got=%0d exp=0", bad4); end
    checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy4); end
    checks++; if (val8 !== 1'b0) begin failures++; $display("FAIL reset_valid8 got=%b exp=0", val8); end
    @(posedge mii_clk); #2;
    reset = 1'b0;
    tick4(1'b0, 4'h0, 1'b0);
    tick4(1'b0, 4'h0, 1'b0);
  endtask

  task automatic test_mii_basic;
    logic [10:0] got, exp, msk;
    cap4.delete();
    pre4(14);
    @(negedge mii_clk);
    checks++; if (busy4 !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy4); end
    pay4(8'h01, 1'b0); pay4(8'h02, 1'b0); pay4(8'h03, 1'b0);
    tick4(1'b0, 4'h0, 1'b0);
    @(negedge mii_clk);
    checks++; if ({val4, eof4, dat4} !== {1'b1, 1'b0, 8'h02}) begin
      failures++; $display("FAIL basic_lat1 got=%b/%b/%h exp=1/0/02", val4, eof4, dat4); end
    @(negedge mii_clk);
    checks++; if ({val4, eof4, dat4} !== {1'b1, 1'b1, 8'h03}) begin
      failures++; $display("FAIL basic_lat2 got=%b/%b/%h exp=1/1/03", val4, eof4, dat4); end
    settle4(3, 50);
    checks++; if (cap4.size() != 3) begin failures++; $display("FAIL basic_count got=%0d exp=3", cap4.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < cap4.size()) ? cap4[i] : 11'h7ff;
      exp = {(i == 0), (i == 2), 1'b0, 8'(1 + i)};
      msk = (i == 2) ? 11'h7ff : 11'h6ff;
      checks++; if ((got & msk) !== exp) begin failures++; $display("FAIL basic_entry%0d got=%h exp=%h", i, got & msk, exp); end
    end
    checks++; if (good4 !== 16'd1 || bad4 !== 16'd0) begin
      failures++; $display("FAIL basic_cnt got=%0d/%0d exp=1/0", good4, bad4); end
  endtask

  task automatic test_gmii_single;
    cap8.delete();
    pre8(7);
    tick8(1'b1, 8'hAA, 1'b0);
    tick8(1'b0, 8'h00, 1'b0);
    settle8(1, 50);
    checks++; if (cap8.size() != 1) begin failures++; $display("FAIL gmii_count got=%0d exp=1", cap8.size()); end
    checks++; if (cap8.size() > 0 && cap8[0] !== {3'b110, 8'hAA}) begin
      failures++; $display("FAIL gmii_entry got=%h exp=%h", cap8[0], {3'b110, 8'hAA}); end
    checks++; if (good8 !== 16'd1 || bad8 !== 16'd0) begin
      failures++; $display("FAIL gmii_cnt got=%0d/%0d exp=1/0", good8, bad8); end
  endtask

  task automatic test_rx_error;
    logic [10:0] got, exp, msk;
    cap4.delete();
    pre4(14);
    for (int i = 0; i < 5; i++) pay4(8'(8'h10 + i), (i == 2));
    tick4(1'b0, 4'h0, 1'b0);
    settle4(5, 50);
    checks++; if (cap4.size() != 5) begin failures++; $display("FAIL rxerr_count got=%0d exp=5", cap4.size()); end
    for (int i = 0; i < 5; i++) begin
      got = (i < cap4.size()) ? cap4[i] : 11'h7ff;
      exp = {(i == 0), (i == 4), (i == 4), 8'(8'h10 + i)};
      msk = (i == 4) ? 11'h7ff : 11'h6ff;
      checks++; if ((got & msk) !== exp) begin failures++; $display("FAIL rxerr_entry%0d got=%h exp=%h", i, got & msk, exp); end
    end
    checks++; if (good4 !== 16'd1 || bad4 !== 16'd1) begin
      failures++; $display("FAIL rxerr_cnt got=%0d/%0d exp=1/1", good4, bad4); end
  endtask

  task automatic test_overflow;
    logic [10:0] got, exp, msk;
    cap4.delete();
    rdy4 = 1'b0;
    pre4(14);
    for (int i = 0; i < 40; i++) pay4(8'(8'h20 + i), 1'b0);
    tick4(1'b0, 4'h0, 1'b0);
    repeat (4) @(negedge mii_clk);
    checks++; if ({val4, sof4, dat4} !== {1'b1, 1'b1, 8'h20}) begin
      failures++; $display("FAIL ovf_head got=%b/%b/%h exp=1/1/20", val4, sof4, dat4); end
    checks++; if (bad4 !== 16'd2) begin failures++; $display("FAIL ovf_bad got=%0d exp=2", bad4); end
    @(posedge mii_clk); #2;
    rdy4 = 1'b1;
    settle4(16, 100);
    checks++; if (cap4.size() != 16) begin failures++; $display("FAIL ovf_count got=%0d exp=16", cap4.size()); end
    for (int i = 0; i < 16; i++) begin
      got = (i < cap4.size()) ? cap4[i] : 11'h7ff;
      exp = {(i == 0), (i == 15), (i == 15), 8'(8'h20 + i)};
      msk = (i == 15) ? 11'h7ff : 11'h6ff;
      checks++; if ((got & msk) !== exp) begin failures++; $display("FAIL ovf_entry%0d got=%h exp=%h", i, got & msk, exp); end
    end
  endtask

  task automatic test_preamble_error;
    logic [10:0] got, exp, msk;
    cap8.delete();
    tick8(1'b1, 8'h55, 1'b0); tick8(1'b1, 8'h55, 1'b0); tick8(1'b1, 8'hA5, 1'b0);
    tick8(1'b0, 8'h00, 1'b0); tick8(1'b0, 8'h00, 1'b0);
    pre8(7);
    for (int i = 0; i < 3; i++) tick8(1'b1, 8'(8'h61 + i), 1'b0);
    tick8(1'b0, 8'h00, 1'b0);
    settle8(3, 50);
    checks++; if (cap8.size() != 3) begin failures++; $display("FAIL prerr_count got=%0d exp=3", cap8.size()); end
    for (int i = 0; i < 3; i++) begin
      got = (i < cap8.size()) ? cap8[i] : 11'h7ff;
      exp = {(i == 0), (i == 2), 1'b0, 8'(8'h61 + i)};
      msk = (i == 2) ? 11'h7ff : 11'h6ff;
      checks++; if ((got & msk) !== exp) begin failures++; $display("FAIL prerr_entry%0d got=%h exp=%h", i, got & msk, exp); end
    end
    checks++; if (good8 !== 16'd2 || bad8 !== 16'd1) begin
      failures++; $display("FAIL prerr_cnt got=%0d/%0d exp=2/1", good8, bad8); end
  endtask

  task automatic test_max_len;
    logic [10:0] got, exp, msk;
    int bad_entries = 0;
    cap8.delete();
    pre8(7);
    for (int i = 0; i < 70; i++) tick8(1'b1, 8'(8'h80 + i), 1'b0);
    tick8(1'b0, 8'h00, 1'b0);
    settle8(64, 200);
    checks++; if (cap8.size() != 64) begin failures++; $display("FAIL maxlen_count got=%0d exp=64", cap8.size()); end
    for (int i = 0; i < 64; i++) begin
      got = (i < cap8.size()) ? cap8[i] : 11'h7ff;
      exp = {(i == 0), (i == 63), (i == 63), 8'(8'h80 + i)};
      msk = (i == 63) ? 11'h7ff : 11'h6ff;
      if ((got & msk) !== exp) begin
        if (bad_entries == 0) $display("FAIL maxlen_entry%0d got=%h exp=%h", i, got & msk, exp);
        bad_entries++;
      end
    end
    checks++; if (bad_entries != 0) begin failures++; $display("FAIL maxlen_entries got=%0d wrong exp=0", bad_entries); end
    checks++; if (good8 !== 16'd2 || bad8 !== 16'd2) begin
      failures++; $display("FAIL maxlen_cnt got=%0d/%0d exp=2/2", good8, bad8); end
  endtask

  task automatic test_zero_byte;
    cap4.delete();
    pre4(14);
    tick4(1'b0, 4'h0, 1'b0);
    repeat (6) @(negedge mii_clk);
    checks++; if (cap4.size() != 0 || val4 !== 1'b0) begin
      failures++; $display("FAIL zero_entries got=%0d/%b exp=0/0", cap4.size(), val4); end
    checks++; if (good4 !== 16'd1 || bad4 !== 16'd3) begin
      failures++; $display("FAIL zero_cnt got=%0d/%0d exp=1/3", good4, bad4); end
    checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL zero_busy got=%b exp=0", busy4); end
  endtask

  task automatic test_dangling;
    cap4.delete();
    pre4(14);
    pay4(8'h31, 1'b0); pay4(8'h32, 1'b0);
    tick4(1'b1, 4'h3, 1'b0);
    tick4(1'b0, 4'h0, 1'b0);
    settle4(2, 50);
    checks++; if (cap4.size() != 2) begin failures++; $display("FAIL dangle_count got=%0d exp=2", cap4.size()); end
    checks++; if (cap4.size() > 0 && (cap4[0] & 11'h6ff) !== {3'b100, 8'h31}) begin
      failures++; $display("FAIL dangle_first got=%h exp=%h", cap4[0] & 11'h6ff, {3'b100, 8'h31}); end
    checks++; if (cap4.size() > 1 && cap4[1] !== {3'b011, 8'h32}) begin
      failures++; $display("FAIL dangle_last got=%h exp=%h", cap4[1], {3'b011, 8'h32}); end
    checks++; if (bad4 !== 16'd4) begin failures++; $display("FAIL dangle_bad got=%0d exp=4", bad4); end
  endtask

  task automatic test_reset_midframe;
    cap4.delete();
    rdy4 = 1'b0;
    pre4(14);
    for (int i = 0; i < 5; i++) pay4(8'(8'h40 + i), 1'b0);
    @(negedge mii_clk);
    checks++; if (val4 !== 1'b1) begin failures++; $display("FAIL mid_prefill got=%b exp=1", val4); end
    @(posedge mii_clk); #2;
    reset = 1'b1; dv4 = 1'b0; d4 = 4'h0;
    @(posedge mii_clk);
    @(negedge mii_clk);
    checks++; if (val4 !== 1'b0 || busy4 !== 1'b0) begin
      failures++; $display("FAIL mid_flush got=%b/%b exp=0/0", val4, busy4); end
    checks++; if (good4 !== 16'd0 || bad4 !== 16'd0 || good8 !== 16'd0 || bad8 !== 16'd0) begin
      failures++; $display("FAIL mid_cnt got=%0d/%0d/%0d/%0d exp=0/0/0/0", good4, bad4, good8, bad8); end
    rdy4 = 1'b1;
    // Frame already in progress as reset lifts must be ignored entirely.
    @(posedge mii_clk); #2;
    reset = 1'b0; dv4 = 1'b1; d4 = 4'h5; er4 = 1'b0;
    repeat (13) tick4(1'b1, 4'h5, 1'b0);
    tick4(1'b1, 4'hD, 1'b0);
    pay4(8'h50, 1'b0); pay4(8'h51, 1'b0);
    @(negedge mii_clk);
    checks++; if (busy4 !== 1'b1) begin failures++; $display("FAIL drop_busy got=%b exp=1", busy4); end
    tick4(1'b0, 4'h0, 1'b0);
    tick4(1'b0, 4'h0, 1'b0);
    repeat (4) @(negedge mii_clk);
    checks++; if (cap4.size() != 0 || good4 !== 16'd0 || bad4 !== 16'd0) begin
      failures++; $display("FAIL drop_result got=%0d/%0d/%0d exp=0/0/0", cap4.size(), good4, bad4); end
    pre4(14);
    pay4(8'h77, 1'b0);
    tick4(1'b0, 4'h0, 1'b0);
    settle4(1, 50);
    checks++; if (cap4.size() != 1 || cap4[0] !== {3'b110, 8'h77}) begin
      failures++; $display("FAIL after_reset got=%0d entries head=%h exp=1 entries %h", cap4.size(), (cap4.size() > 0) ? cap4[0] : 11'h0, {3'b110, 8'h77}); end
    checks++; if (good4 !== 16'd1) begin failures++; $display("FAIL after_reset_good got=%0d exp=1", good4); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    dv4 = 1'b0; er4 = 1'b0; d4 = 4'h0; rdy4 = 1'b1;
    dv8 = 1'b0; er8 = 1'b0; d8 = 8'h00; rdy8 = 1'b1;
    test_reset;
    test_mii_basic;
    test_gmii_single;
    test_rx_error;
    test_overflow;
    test_preamble_error;
    test_max_len;
    test_zero_byte;
    test_dangling;
    test_reset_midframe;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
